// File: rtl/x86_instr_encoder.sv
// Serialises one IA-32 ADD/MOV r/m instruction (opcode, ModRM, optional SIB, displacement)
// as a valid/ready byte stream. Define X86_ENC_SIB_EN to emit SIB forms; otherwise they are rejected.
module x86_instr_encoder #(
  parameter int OPC_W  = 8,
  parameter int DISP_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [1:0]        i_mod,
  input  logic [2:0]        i_reg,
  input  logic [2:0]        i_rm,
  input  logic [7:0]        i_sib,
  input  logic [DISP_W-1:0] i_disp,
  output logic [7:0]        o_byte,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_last,
  output logic [2:0]        o_instr_len,
  output logic              o_err
);

  typedef enum logic [2:0] {
    IDLE, OPC, MODRM, SIB, DISP, ERR
  } state_t;

  state_t state_reg, state_next;

  logic [OPC_W-1:0]  opcode_reg;
  logic [7:0]        modrm_reg;
  logic [7:0]        sib_reg;
  logic [DISP_W-1:0] disp_reg;
  logic              has_sib_reg, has_disp_reg, disp4_reg;
  logic [1:0]        disp_cnt_reg;
  logic [2:0]        len_reg;

  logic acc_sib, acc_disp, acc_disp4, acc_bad;
  logic accept, xfer, disp_done;

  assign accept    = i_req_valid && (state_reg == IDLE);
  assign xfer      = o_byte_valid && i_byte_ready;
  assign disp_done = !disp4_reg || (disp_cnt_reg == 2'd3);

  // Classify the request at accept time: SIB presence, displacement size, rejection.
  always_comb begin
    acc_sib   = 1'b0;
    acc_disp  = 1'b0;
    acc_disp4 = 1'b0;
    acc_bad   = 1'b0;
    case (i_opcode)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h89, 8'h8B: acc_bad = 1'b0;
      default:                                  acc_bad = 1'b1;
    endcase
    if (i_mod != 2'b11) begin
      if (i_mod == 2'b01) begin
        acc_disp = 1'b1;
      end else if (i_mod == 2'b10) begin
        acc_disp  = 1'b1;
        acc_disp4 = 1'b1;
      end
      if (i_rm == 3'b100) begin
`ifdef X86_ENC_SIB_EN
        acc_sib = 1'b1;
        if (i_mod == 2'b00 && i_sib[2:0] == 3'b101) begin
          acc_disp  = 1'b1;
          acc_disp4 = 1'b1;
        end
`else
        acc_bad = 1'b1;
`endif
      end else if (i_mod == 2'b00 && i_rm == 3'b101) begin
        acc_disp  = 1'b1;
        acc_disp4 = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      modrm_reg    <= '0;
      sib_reg      <= '0;
      disp_reg     <= '0;
      has_sib_reg  <= 1'b0;
      has_disp_reg <= 1'b0;
      disp4_reg    <= 1'b0;
      disp_cnt_reg <= 2'd0;
      len_reg      <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opcode_reg   <= i_opcode;
        modrm_reg    <= {i_mod, i_reg, i_rm};
        sib_reg      <= i_sib;
        disp_reg     <= i_disp;
        has_sib_reg  <= acc_sib;
        has_disp_reg <= acc_disp;
        disp4_reg    <= acc_disp4;
        disp_cnt_reg <= 2'd0;
        len_reg      <= 3'd2 + {2'b00, acc_sib} + (acc_disp4 ? 3'd4 : {2'b00, acc_disp});
      end else if (state_reg == DISP && xfer) begin
        disp_cnt_reg <= disp_cnt_reg + 2'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (i_req_valid) state_next = acc_bad ? ERR : OPC;
      OPC:   if (xfer) state_next = MODRM;
      MODRM: if (xfer) state_next = has_sib_reg ? SIB : (has_disp_reg ? DISP : IDLE);
      SIB:   if (xfer) state_next = has_disp_reg ? DISP : IDLE;
      DISP:  if (xfer && disp_done) state_next = IDLE;
      ERR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from the state alone, so they stay stable while the sink stalls.
  always_comb begin
    o_byte       = 8'h00;
    o_byte_valid = 1'b0;
    o_last       = 1'b0;
    case (state_reg)
      OPC: begin
        o_byte       = opcode_reg[7:0];
        o_byte_valid = 1'b1;
      end
      MODRM: begin
        o_byte       = modrm_reg;
        o_byte_valid = 1'b1;
        o_last       = !has_sib_reg && !has_disp_reg;
      end
      SIB: begin
        o_byte       = sib_reg;
        o_byte_valid = 1'b1;
        o_last       = !has_disp_reg;
      end
      DISP: begin
        o_byte       = disp_reg[{disp_cnt_reg, 3'b000} +: 8];
        o_byte_valid = 1'b1;
        o_last       = disp_done;
      end
      default: ;
    endcase
  end

  assign o_req_ready = (state_reg == IDLE);
  assign o_err       = (state_reg == ERR);
  assign o_instr_len = o_byte_valid ? len_reg : 3'd0;

endmodule

// File: tb/tb_x86_instr_encoder.sv
// Directed-vector bench for x86_instr_encoder; drives and samples on the falling clock edge.
module tb_x86_instr_encoder;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [7:0]  i_opcode = '0;
  logic [1:0]  i_mod = '0;
  logic [2:0]  i_reg = '0;
  logic [2:0]  i_rm = '0;
  logic [7:0]  i_sib = '0;
  logic [31:0] i_disp = '0;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready = 1'b0;
  logic        o_last;
  logic [2:0]  o_instr_len;
  logic        o_err;

  int errors = 0;
  int checks = 0;

  x86_instr_encoder dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_opcode(i_opcode), .i_mod(i_mod), .i_reg(i_reg), .i_rm(i_rm),
    .i_sib(i_sib), .i_disp(i_disp),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_last(o_last), .o_instr_len(o_instr_len), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request for a single cycle; the encoder must be idle.
  task automatic do_req(input logic [7:0] op, input logic [1:0] md, input logic [2:0] rg,
                        input logic [2:0] rm, input logic [7:0] sib, input logic [31:0] disp);
    check("req_ready_before", {31'b0, o_req_ready}, 32'd1);
    i_opcode = op; i_mod = md; i_reg = rg; i_rm = rm; i_sib = sib; i_disp = disp;
    i_req_valid = 1'b1;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    $display("req op=%02h mod=%0d reg=%0d rm=%0d sib=%02h disp=%08h", op, md, rg, rm, sib, disp);
  endtask

  // Receive bytes (first byte in exp[7:0]); stop after 'stop' of 'n' bytes.
  // With toggle set, each byte is first stalled one cycle and must hold.
  task automatic recv(input string tag, input int n, input int stop, input logic [63:0] exp,
                      input int len, input bit toggle);
    for (int i = 0; i < stop; i++) begin
      if (toggle) begin
        i_byte_ready = 1'b0;
        check({tag, "_stall_byte"}, {24'b0, o_byte}, {24'b0, exp[8*i +: 8]});
        @(negedge i_clk);
      end
      i_byte_ready = 1'b1;
      check({tag, "_valid"}, {31'b0, o_byte_valid}, 32'd1);
      check({tag, "_byte"}, {24'b0, o_byte}, {24'b0, exp[8*i +: 8]});
      check({tag, "_last"}, {31'b0, o_last}, {31'b0, (i == n - 1)});
      check({tag, "_len"}, {29'b0, o_instr_len}, len[31:0]);
      $display("byte %s[%0d] = %02h last=%0b len=%0d", tag, i, o_byte, o_last, o_instr_len);
      @(negedge i_clk);
    end
    i_byte_ready = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_idle_ready"}, {31'b0, o_req_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'b0, o_byte_valid}, 32'd0);
  endtask

  task automatic expect_reject(input string tag);
    check({tag, "_err"}, {31'b0, o_err}, 32'd1);
    check({tag, "_err_novalid"}, {31'b0, o_byte_valid}, 32'd0);
    @(negedge i_clk);
    check({tag, "_err_pulse"}, {31'b0, o_err}, 32'd0);
    expect_idle(tag);
    $display("reject %s", tag);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_valid", {31'b0, o_byte_valid}, 32'd0);
    check("rst_last", {31'b0, o_last}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_byte", {24'b0, o_byte}, 32'd0);
    check("rst_len", {29'b0, o_instr_len}, 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);

    // ADD r/m32,r32 register form: 01 C1, ready returns right after.
    do_req(8'h01, 2'b11, 3'd0, 3'd1, 8'h00, 32'h0);
    recv("add_reg", 2, 2, 64'hC101, 2, 1'b0);
    expect_idle("add_reg");

    // MOV with disp8: 8B 43 10.
    do_req(8'h8B, 2'b01, 3'd0, 3'd3, 8'h00, 32'h10);
    recv("mov_d8", 3, 3, 64'h10438B, 3, 1'b0);
    expect_idle("mov_d8");

    // disp32 with stalled sink: 03 96 78 56 34 12.
    do_req(8'h03, 2'b10, 3'd2, 3'd6, 8'h00, 32'h12345678);
    recv("add_d32", 6, 6, 64'h123456789603, 6, 1'b1);
    expect_idle("add_d32");

    // mod=00 rm=101 absolute disp32: 8B 0D EF BE AD DE.
    do_req(8'h8B, 2'b00, 3'd1, 3'd5, 8'h00, 32'hDEADBEEF);
    recv("mov_abs", 6, 6, 64'hDEADBEEF0D8B, 6, 1'b0);

    // mod=00 plain indirect, no displacement: 02 38.
    do_req(8'h02, 2'b00, 3'd7, 3'd0, 8'h00, 32'hFFFFFFFF);
    recv("add_ind", 2, 2, 64'h3802, 2, 1'b0);

    // Unsupported opcode.
    do_req(8'h0F, 2'b11, 3'd0, 3'd0, 8'h00, 32'h0);
    expect_reject("opc_0f");

    // SIB form: emitted when enabled, rejected otherwise.
    do_req(8'h89, 2'b00, 3'd0, 3'd4, 8'h25, 32'hAABBCCDD);
`ifdef X86_ENC_SIB_EN
    recv("mov_sib", 7, 7, 64'hAABBCCDD250489, 7, 1'b0);
    expect_idle("mov_sib");
`else
    expect_reject("mov_sib");
`endif

    // Reset after the second displacement byte drops the rest.
    do_req(8'h03, 2'b10, 3'd2, 3'd6, 8'h00, 32'h12345678);
    recv("rst_mid", 6, 4, 64'h123456789603, 6, 1'b0);
    check("rst_mid_pre_valid", {31'b0, o_byte_valid}, 32'd1);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_mid_valid", {31'b0, o_byte_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, o_req_ready}, 32'd1);
    i_reset = 1'b1;
    @(negedge i_clk);

    // Fresh instruction after reset.
    do_req(8'h00, 2'b11, 3'd7, 3'd7, 8'h00, 32'h0);
    recv("post_rst", 2, 2, 64'hFF00, 2, 1'b0);
    expect_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
